// File: rtl/mem_load_wb_unit_pkg.sv
// mem_load_wb_unit_pkg: vector memory load-return widths, tag entry type and tail byte-enable helper.
package mem_load_wb_unit_pkg;

   localparam int LD_ADDR_WIDTH  = 5;
   localparam int LD_OFF_WIDTH   = 8;
   localparam int LD_DATA_WIDTH  = 64;
   localparam int LD_BYTES_WIDTH = 16;
   localparam int LD_DW_B        = LD_DATA_WIDTH / 8;
   localparam int LD_DW_B_BITS   = $clog2(LD_DW_B);

   // vl_bytes is meaningful only on entries with start set
   typedef struct packed {
      logic [LD_ADDR_WIDTH-1:0]  addr;
      logic [LD_OFF_WIDTH-1:0]   off;
      logic                      start;
      logic                      last;
      logic [LD_BYTES_WIDTH-1:0] vl_bytes;
   } tag_t;

   function automatic logic [LD_DW_B-1:0] be_from_rem(input logic [LD_BYTES_WIDTH-1:0] rem);
      logic [LD_DW_B-1:0] ones;
      ones = '1;
      return (rem >= LD_BYTES_WIDTH'(LD_DW_B)) ? ones : ~(ones << rem[LD_DW_B_BITS-1:0]);
   endfunction

endpackage

// File: rtl/mem_tag_fifo.sv
// mem_tag_fifo: in-order synchronous FIFO; a push at full is taken only when a pop frees a slot that cycle.
module mem_tag_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PW:0]      count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp, rp;
   logic             push_ok, pop_ok;

   assign full    = count == (PW+1)'(DEPTH);
   assign empty   = count == '0;
   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rp];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push_ok) begin
            mem[wp] <= wdata;
            wp      <= wp + 1'b1;
         end
         if (pop_ok) rp <= rp + 1'b1;
         count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
      end
   end

endmodule

// File: rtl/mem_load_wb_unit.sv
// mem_load_wb_unit: pairs memory read beats with queued address tags and drives a registered VRF write.
// Optional protocol checking (err) is built when LD_RESP_CHECK_EN is defined.
module mem_load_wb_unit
   import mem_load_wb_unit_pkg::*;
#(
   parameter int ADDR_WIDTH  = LD_ADDR_WIDTH,
   parameter int OFF_WIDTH   = LD_OFF_WIDTH,
   parameter int DATA_WIDTH  = LD_DATA_WIDTH,
   parameter int BYTES_WIDTH = LD_BYTES_WIDTH,
   parameter int TAG_DEPTH   = 4,
   localparam int DW_B       = DATA_WIDTH / 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tag_en,
   input  logic [ADDR_WIDTH-1:0]  tag_addr,
   input  logic [OFF_WIDTH-1:0]   tag_off,
   input  logic                   tag_start,
   input  logic                   tag_end,
   input  logic [BYTES_WIDTH-1:0] vl_bytes,
   input  logic                   mem_rvalid,
   input  logic [DATA_WIDTH-1:0]  mem_rdata,
   output logic                   tag_full,
   output logic                   wr_en,
   output logic [ADDR_WIDTH-1:0]  wr_addr,
   output logic [OFF_WIDTH-1:0]   wr_off,
   output logic [DATA_WIDTH-1:0]  wr_data,
   output logic [DW_B-1:0]        wr_be,
   output logic                   done,
   output logic                   busy,
   output logic                   err
);
   tag_t                     push_tag, head;
   logic                     empty, pop;
   logic [$clog2(TAG_DEPTH):0] count;
   logic [BYTES_WIDTH-1:0]   rem, cur_rem;
   logic [DW_B-1:0]          be;

   assign push_tag = '{addr: tag_addr, off: tag_off, start: tag_start, last: tag_end,
                       vl_bytes: tag_start ? vl_bytes : '0};
   assign pop      = mem_rvalid & ~empty;
   assign busy     = (count != '0) | wr_en;

   mem_tag_fifo #(.WIDTH($bits(tag_t)), .DEPTH(TAG_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tag_en),
      .wdata (push_tag),
      .pop   (pop),
      .rdata (head),
      .full  (tag_full),
      .empty (empty),
      .count (count)
   );

   // a start beat takes its byte count from the entry; later beats continue from the running counter
   always_comb begin
      cur_rem = head.start ? head.vl_bytes : rem;
      be      = be_from_rem(cur_rem);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem     <= '0;
         wr_en   <= 1'b0;
         wr_be   <= '0;
         done    <= 1'b0;
         wr_addr <= '0;
         wr_off  <= '0;
         wr_data <= '0;
      end else begin
         if (pop) rem <= (cur_rem >= BYTES_WIDTH'(DW_B)) ? cur_rem - BYTES_WIDTH'(DW_B) : '0;
         wr_en <= pop & (|be);
         wr_be <= pop ? be : '0;
         done  <= pop & head.last;
         if (pop & (|be)) begin
            wr_addr <= head.addr;
            wr_off  <= head.off;
            wr_data <= mem_rdata;
         end
      end
   end

`ifdef LD_RESP_CHECK_EN
   logic in_load;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err     <= 1'b0;
         in_load <= 1'b0;
      end else begin
         if ((tag_en & tag_full & ~pop) | (mem_rvalid & empty) | (tag_en & tag_start & in_load))
            err <= 1'b1;
         if (tag_en & (~tag_full | pop)) in_load <= ~tag_end & (tag_start | in_load);
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_load_wb_unit.sv
// tb_mem_load_wb_unit: directed vectors with hand-computed expectations for mem_load_wb_unit.
module tb_mem_load_wb_unit;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        tag_en = 1'b0, tag_start = 1'b0, tag_end = 1'b0, mem_rvalid = 1'b0;
   logic [4:0]  tag_addr = '0;
   logic [7:0]  tag_off = '0;
   logic [15:0] vl_bytes = '0;
   logic [63:0] mem_rdata = '0;
   logic        tag_full, wr_en, done, busy, err;
   logic [4:0]  wr_addr;
   logic [7:0]  wr_off;
   logic [63:0] wr_data;
   logic [7:0]  wr_be;
   int          total = 0, bad = 0;

`ifdef LD_RESP_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_load_wb_unit dut (
      .clk(clk), .rst_n(rst_n), .tag_en(tag_en), .tag_addr(tag_addr), .tag_off(tag_off),
      .tag_start(tag_start), .tag_end(tag_end), .vl_bytes(vl_bytes), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .tag_full(tag_full), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_off(wr_off), .wr_data(wr_data), .wr_be(wr_be), .done(done), .busy(busy), .err(err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [4:0] a, input logic [7:0] o, input logic s,
                        input logic e, input logic [15:0] vl, input logic rv, input logic [63:0] d);
      tag_en = en; tag_addr = a; tag_off = o; tag_start = s; tag_end = e; vl_bytes = vl;
      mem_rvalid = rv; mem_rdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0, 64'd0);
   endtask

   task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [7:0] o,
                         input logic [63:0] d, input logic [7:0] be, input logic dn);
      check({tag, ".wr_en"}, wr_en, en);
      check({tag, ".wr_be"}, wr_be, be);
      check({tag, ".done"}, done, dn);
      if (en) begin
         check({tag, ".wr_addr"}, wr_addr, a);
         check({tag, ".wr_off"}, wr_off, o);
         check({tag, ".wr_data"}, wr_data, d);
      end
   endtask

   initial begin
      idle();
      idle();
      check("rst.wr_en", wr_en, 1'b0);
      check("rst.wr_be", wr_be, 8'h00);
      check("rst.done", done, 1'b0);
      check("rst.err", err, 1'b0);
      check("rst.busy", busy, 1'b0);
      check("rst.full", tag_full, 1'b0);
      check("rst.wr_addr", wr_addr, 5'd0);
      check("rst.wr_data", wr_data, 64'd0);
      rst_n = 1'b1;

      // single load of 20 bytes, responses trail pushes by one cycle
      drive(1'b1, 5'd3, 8'd0, 1'b1, 1'b0, 16'd20, 1'b0, 64'd0);
      drive(1'b1, 5'd3, 8'd1, 1'b0, 1'b0, 16'd0, 1'b1, 64'hA0A0_0000_0000_0001);
      chk_wr("l20.b0", 1'b1, 5'd3, 8'd0, 64'hA0A0_0000_0000_0001, 8'hFF, 1'b0);
      drive(1'b1, 5'd3, 8'd2, 1'b0, 1'b1, 16'd0, 1'b1, 64'hA0A0_0000_0000_0002);
      chk_wr("l20.b1", 1'b1, 5'd3, 8'd1, 64'hA0A0_0000_0000_0002, 8'hFF, 1'b0);
      check("l20.busy", busy, 1'b1);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hA0A0_0000_0000_0003);
      chk_wr("l20.b2", 1'b1, 5'd3, 8'd2, 64'hA0A0_0000_0000_0003, 8'h0F, 1'b1);
      idle();
      chk_wr("l20.idle", 1'b0, 5'd0, 8'd0, 64'd0, 8'h00, 1'b0);
      check("l20.busy_end", busy, 1'b0);
      check("l20.err", err, 1'b0);

      // 16 bytes over three beats: last beat writes nothing but still completes
      drive(1'b1, 5'd7, 8'd0, 1'b1, 1'b0, 16'd16, 1'b0, 64'd0);
      drive(1'b1, 5'd7, 8'd1, 1'b0, 1'b0, 16'd0, 1'b0, 64'd0);
      drive(1'b1, 5'd7, 8'd2, 1'b0, 1'b1, 16'd0, 1'b0, 64'd0);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hB1);
      chk_wr("l16.b0", 1'b1, 5'd7, 8'd0, 64'hB1, 8'hFF, 1'b0);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hB2);
      chk_wr("l16.b1", 1'b1, 5'd7, 8'd1, 64'hB2, 8'hFF, 1'b0);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hB3);
      chk_wr("l16.b2", 1'b0, 5'd0, 8'd0, 64'd0, 8'h00, 1'b1);
      check("l16.hold_off", wr_off, 8'd1);
      check("l16.hold_data", wr_data, 64'hB2);
      idle();
      check("l16.done_clr", done, 1'b0);
      check("l16.busy_end", busy, 1'b0);

      // fill the FIFO, then push and pop together at full
      drive(1'b1, 5'd1, 8'd0, 1'b1, 1'b0, 16'd32, 1'b0, 64'd0);
      drive(1'b1, 5'd1, 8'd1, 1'b0, 1'b0, 16'd0, 1'b0, 64'd0);
      drive(1'b1, 5'd1, 8'd2, 1'b0, 1'b0, 16'd0, 1'b0, 64'd0);
      drive(1'b1, 5'd1, 8'd3, 1'b0, 1'b1, 16'd0, 1'b0, 64'd0);
      check("full.set", tag_full, 1'b1);
      check("full.err0", err, 1'b0);
      drive(1'b1, 5'd1, 8'd4, 1'b1, 1'b1, 16'd8, 1'b1, 64'hC0);
      check("full.keep", tag_full, 1'b1);
      check("full.err1", err, 1'b0);
      chk_wr("full.b0", 1'b1, 5'd1, 8'd0, 64'hC0, 8'hFF, 1'b0);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hC1);
      check("full.clr", tag_full, 1'b0);
      chk_wr("full.b1", 1'b1, 5'd1, 8'd1, 64'hC1, 8'hFF, 1'b0);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hC2);
      chk_wr("full.b2", 1'b1, 5'd1, 8'd2, 64'hC2, 8'hFF, 1'b0);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hC3);
      chk_wr("full.b3", 1'b1, 5'd1, 8'd3, 64'hC3, 8'hFF, 1'b1);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hC4);
      chk_wr("full.b4", 1'b1, 5'd1, 8'd4, 64'hC4, 8'hFF, 1'b1);
      idle();
      check("full.busy_end", busy, 1'b0);
      check("full.err2", err, 1'b0);

      // response with nothing queued
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hDD);
      chk_wr("empty.rsp", 1'b0, 5'd0, 8'd0, 64'd0, 8'h00, 1'b0);
      check("empty.err", err, CHK);
      idle();
      check("empty.sticky", err, CHK);
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      check("empty.err_rst", err, 1'b0);

      // second load queued before the first drains: 12 bytes then 8 bytes
      drive(1'b1, 5'd2, 8'd0, 1'b1, 1'b0, 16'd12, 1'b0, 64'd0);
      drive(1'b1, 5'd2, 8'd1, 1'b0, 1'b1, 16'd0, 1'b1, 64'hE0);
      chk_wr("two.b0", 1'b1, 5'd2, 8'd0, 64'hE0, 8'hFF, 1'b0);
      drive(1'b1, 5'd4, 8'd0, 1'b1, 1'b1, 16'd8, 1'b0, 64'd0);
      chk_wr("two.gap", 1'b0, 5'd0, 8'd0, 64'd0, 8'h00, 1'b0);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hE1);
      chk_wr("two.b1", 1'b1, 5'd2, 8'd1, 64'hE1, 8'h0F, 1'b1);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hE2);
      chk_wr("two.b2", 1'b1, 5'd4, 8'd0, 64'hE2, 8'hFF, 1'b1);
      idle();
      check("two.err", err, 1'b0);
      check("two.busy_end", busy, 1'b0);

      // reset mid-load with two tags queued and a response in the reset cycle
      drive(1'b1, 5'd5, 8'd0, 1'b1, 1'b0, 16'd16, 1'b0, 64'd0);
      drive(1'b1, 5'd5, 8'd1, 1'b0, 1'b0, 16'd0, 1'b0, 64'd0);
      check("mid.busy_pre", busy, 1'b1);
      rst_n = 1'b0;
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hF0);
      rst_n = 1'b1;
      check("mid.busy", busy, 1'b0);
      check("mid.wr_en", wr_en, 1'b0);
      check("mid.err_rst", err, 1'b0);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hF1);
      chk_wr("mid.rsp0", 1'b0, 5'd0, 8'd0, 64'd0, 8'h00, 1'b0);
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'hF2);
      chk_wr("mid.rsp1", 1'b0, 5'd0, 8'd0, 64'd0, 8'h00, 1'b0);
      check("mid.err", err, CHK);

      // push while full with no pop is dropped
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      drive(1'b1, 5'd6, 8'd0, 1'b1, 1'b0, 16'd40, 1'b0, 64'd0);
      for (int i = 1; i < 4; i++) drive(1'b1, 5'd6, 8'(i), 1'b0, 1'b0, 16'd0, 1'b0, 64'd0);
      check("drop.err0", err, 1'b0);
      drive(1'b1, 5'd6, 8'd4, 1'b0, 1'b1, 16'd0, 1'b0, 64'd0);
      check("drop.full", tag_full, 1'b1);
      check("drop.err", err, CHK);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'(i));
         chk_wr("drop.drain", 1'b1, 5'd6, 8'(i), 64'(i), 8'hFF, 1'b0);
      end
      drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 64'h55);
      chk_wr("drop.extra", 1'b0, 5'd0, 8'd0, 64'd0, 8'h00, 1'b0);
      idle();
      check("drop.busy_end", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_load_wb_unit.md
Name: mem_load_wb_unit

Overview:
- Load-return stage directly downstream of the vector memory address generator.
- Per memory beat the generator emits one tag: VRF register, element offset, start, end. This block queues those tags in order.
- Pairs each memory read response with the oldest tag, then drives a registered vector-register-file write with a tail byte mask derived from the load's byte count.
- Signals load completion to the vector control logic.

Parameters:
ADDR_WIDTH, 5, VRF register index width
OFF_WIDTH, 8, element offset width within a register group
DATA_WIDTH, 64, memory/VRF beat width in bits
DW_B, 8, bytes per beat (DATA_WIDTH/8)
DW_B_BITS, 3, log2(DW_B)
BYTES_WIDTH, 16, width of the load byte-count input
TAG_DEPTH, 4, tag FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
tag_en  in  1  push tag (driven from generator enable/activity)
tag_addr  in  ADDR_WIDTH  VRF register for this beat
tag_off  in  OFF_WIDTH  element offset for this beat
tag_start  in  1  first beat of a load
tag_end  in  1  last beat of a load
vl_bytes  in  BYTES_WIDTH  total valid bytes of the load, sampled on tag_en & tag_start
mem_rvalid  in  1  memory read data valid
mem_rdata  in  DATA_WIDTH  memory read data
tag_full  out  1  tag FIFO full; generator must stall
wr_en  out  1  VRF write strobe
wr_addr  out  ADDR_WIDTH  VRF register
wr_off  out  OFF_WIDTH  VRF element offset
wr_data  out  DATA_WIDTH  write data
wr_be  out  DW_B  byte enables
done  out  1  one-cycle pulse: last beat of a load written
busy  out  1  FIFO non-empty or write pending
err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n low at a clk edge): FIFO count/pointers 0, byte counter 0, wr_en/done/err 0, wr_be 0, wr_addr/wr_off/wr_data 0. Applies mid-load: in-flight tags are discarded and responses in the same cycle are ignored.
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Tag FIFO: in-order, TAG_DEPTH entries of {addr, off, start, end}. tag_full = (count == TAG_DEPTH).
- Push when tag_en is high. Pop when mem_rvalid is high and the FIFO is non-empty.
- Full FIFO with push and pop in the same cycle: both accepted, count unchanged. Full FIFO with push and no pop: push dropped, err set.
- Empty FIFO with same-cycle push and mem_rvalid: the response is not paired (no bypass). err is set and the pushed tag is stored.
- Byte counter rem: loaded with vl_bytes when the pushed tag has start. Each popped beat:
  - rem >= DW_B: be = all ones, rem -= DW_B.
  - 0 < rem < DW_B: be = (1<<rem)-1, rem = 0.
  - rem == 0: be = 0.
  - Counter is saturating, never wraps.
- Ordering constraint: rem is per-load. Tags of a second load may be pushed before the first drains, so rem is captured into a per-entry byte-count field at push time and decremented in a small per-load register at pop time. The FIFO entry therefore also carries vl_bytes, valid only when start is set.
- Output stage, registered, latency 1 cycle from mem_rvalid:
  - wr_en = pop & (be != 0).
  - wr_addr/wr_off/wr_data/wr_be from the popped tag and data.
  - done = pop & tag.end, asserted regardless of be.
- Outputs hold their last values when wr_en = 0. wr_be is forced to 0 when wr_en = 0.
- busy = (count != 0) | wr_en.
- err: sticky until reset.

Optional Feature:
- Macro LD_RESP_CHECK_EN.
- Defined:
  - err logic as above.
  - A response with an empty FIFO is flagged and dropped.
  - A start tag pushed while a previous load's end has not yet been pushed is also flagged.
- Undefined:
  - err tied to 0; no check logic.
  - A response with an empty FIFO is silently dropped.
  - A push at full is silently dropped.

Decomposition:
- Shared package (vector memory package): DW_B/DW_B_BITS derivation, a tag struct typedef {addr, off, start, end, vl_bytes}, and a byte-enable-from-remaining function.
- One sub-module: mem_tag_fifo, a parameterised synchronous FIFO with full/empty/count, supporting simultaneous push and pop at full.

Test Plan:
- Single load, vl_bytes=20, DW_B=8, tags r3 off 0..2 (start on first, end on last), three responses one cycle later:
  - writes r3 with be 0xFF, 0xFF, 0x0F.
  - done is high with the third write only.
- vl_bytes=16 with three tags:
  - third beat gives wr_en=0 and done=1.
  - only two writes occur.
- Push 4 tags with no responses -> tag_full=1. Then push and respond in the same cycle -> tag_full stays 1, count stays 4, err=0.
- mem_rvalid with an empty FIFO:
  - with the macro defined -> err=1, no write.
  - without the macro -> err=0.
- Two back-to-back loads (vl_bytes 12 then 8) with interleaved latency -> be sequence 0xFF, 0x0F, 0xFF and two done pulses.
- Assert rst_n=0 mid-load with 2 tags queued -> next cycle busy=0, wr_en=0, and subsequent responses cause no writes.
